// File: rtl/seq_alu.sv
// Multi-cycle 32-bit ALU with start/done handshake; shifts iterate one bit per cycle.
// Optional overflow flag on ADD/SUB is enabled by defining SEQ_ALU_OVF_EN.
module seq_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  Alu_Signal,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  state_t             state;
  logic [4:0]         count;
  logic [3:0]         op_p0;
  logic signed [31:0] a_p0;
  logic signed [31:0] b_p0;
  logic [31:0]        exec_res;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic [31:0] alu_exec(input logic [3:0] op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
      OP_LUI:  return {b[15:0], 16'h0000};
      OP_NOR:  return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] shift_step(input logic [3:0] op, input logic [31:0] s);
    case (op)
      OP_SLL:  return {s[30:0], 1'b0};
      OP_SRL:  return {1'b0, s[31:1]};
      OP_SRA:  return {s[31], s[31:1]};
      default: return s;
    endcase
  endfunction

`ifdef SEQ_ALU_OVF_EN
  function automatic logic ovf_flag(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] r);
    case (op)
      OP_ADD:  return (a[31] == b[31]) && (r[31] != a[31]);
      OP_SUB:  return (a[31] != b[31]) && (r[31] != a[31]);
      default: return 1'b0;
    endcase
  endfunction
`endif

  assign exec_res = alu_exec(op_p0, a_p0, b_p0);

  // Control and result registers: reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
      zero     <= 1'b1;
      count    <= 5'd0;
`ifdef SEQ_ALU_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            count <= shamt;
            state <= is_shift(Alu_Signal) ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          result   <= exec_res;
          zero     <= (exec_res == 32'd0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
`ifdef SEQ_ALU_OVF_EN
          overflow <= ovf_flag(op_p0, a_p0, b_p0, exec_res);
`endif
        end
        SHIFT: begin
          if (count != 5'd0) begin
            count <= count - 5'd1;
          end else begin
            result   <= b_p0;
            zero     <= (b_p0 == 32'd0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef SEQ_ALU_OVF_EN
            overflow <= 1'b0;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand latch; b_p0 doubles as the shift register
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_p0 <= Alu_Signal;
      a_p0  <= A;
      b_p0  <= B;
    end else if (state == SHIFT && count != 5'd0) begin
      b_p0  <= shift_step(op_p0, b_p0);
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: table of single operations plus reset,
// back-to-back and start-while-busy sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  Alu_Signal;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
`ifdef SEQ_ALU_OVF_EN
  logic        overflow;
`endif

  seq_alu dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Alu_Signal (Alu_Signal),
    .A          (A),
    .B          (B),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero)
`ifdef SEQ_ALU_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] res, input logic z,
                     input logic ovf, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.z = z; v.ovf = ovf; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    Alu_Signal = v.op; A = v.a; B = v.b; shamt = v.sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Alu_Signal = ~v.op; A = ~v.a; B = ~v.b; shamt = ~v.sh;
    check($sformatf("v%0d_busy_d0", idx), {31'd0, busy}, 32'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_result", idx), result, v.res);
    check($sformatf("v%0d_zero", idx), {31'd0, zero}, {31'd0, v.z});
    check($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_busy_held", idx), {31'd0, busy_ok}, 32'd1);
`ifdef SEQ_ALU_OVF_EN
    check($sformatf("v%0d_overflow", idx), {31'd0, overflow}, {31'd0, v.ovf});
`endif
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; Alu_Signal = 4'd0; A = 32'd0; B = 32'd0; shamt = 5'd0;

    //        op       A             B             sh     result        z  ovf lat
    add(4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 0, 0, 1);
    add(4'b0001, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 0, 0, 1);
    add(4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 0, 1, 1);
    add(4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1, 0, 1);
    add(4'b0011, 32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00, 0, 0, 1);
    add(4'b0110, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1, 0, 1);
    add(4'b0110, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 0, 1, 1);
    add(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 0, 0, 1);
    add(4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1, 0, 1);
    add(4'b1010, 32'hDEADBEEF, 32'h00001234, 5'd0,  32'h12340000, 0, 0, 1);
    add(4'b1100, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 0, 0, 1);
    add(4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h00000000, 1, 0, 1);
    add(4'b0101, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000, 1, 0, 1);
    add(4'b0100, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 0, 0, 1);
    add(4'b0100, 32'h00000000, 32'h00000001, 5'd4,  32'h00000010, 0, 0, 5);
    add(4'b1001, 32'h00000000, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0, 0, 32);
    add(4'b1000, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 0, 0, 32);
    add(4'b1001, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 0, 0, 5);
    add(4'b1000, 32'h00000000, 32'h00000010, 5'd5,  32'h00000000, 1, 0, 6);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SEQ_ALU_OVF_EN
    check("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back: start held high across AND then OR
    @(negedge clk);
    Alu_Signal = 4'b0000; A = 32'h0000F0F0; B = 32'h0000FF00; start = 1'b1;
    @(negedge clk);
    Alu_Signal = 4'b0001;
    @(negedge clk);
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_result1", result, 32'h0000F000);
    @(negedge clk);
    start = 1'b0;
    check("b2b_gap_done", {31'd0, done}, 32'd0);
    check("b2b_gap_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_result2", result, 32'h0000FFF0);
    @(negedge clk);
    check("b2b_done2_one_cycle", {31'd0, done}, 32'd0);

    // start pulsed while busy is ignored
    @(negedge clk);
    Alu_Signal = 4'b0100; A = 32'd0; B = 32'h00000003; shamt = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    Alu_Signal = 4'b0010; A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        check("ignore_result", result, 32'h00000030);
        if (seen_done) check("ignore_extra_done", 32'd1, 32'd0);
        seen_done = 1'b1;
      end
    end
    check("ignore_one_done", {31'd0, seen_done}, 32'd1);
    check("ignore_idle", {31'd0, busy}, 32'd0);
    check("ignore_result_held", result, 32'h00000030);

    // Reset mid-SHIFT aborts asynchronously with no done afterwards
    @(negedge clk);
    Alu_Signal = 4'b0100; A = 32'd0; B = 32'd1; shamt = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_rst", {31'd0, seen_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 32-bit ALU for the datapath. It executes the 4-bit operation code produced by the ALU control decoder, using a start/done handshake. Logic and arithmetic operations complete in one cycle; shifts iterate one bit per cycle so no barrel shifter is needed. It sits between the register-file read ports and the write-back/branch logic, and the main control FSM stalls on `busy`.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `Alu_Signal` input 4: operation code, latched on accept.
- `A` input 32: operand rs, latched on accept.
- `B` input 32: operand rt/immediate, latched on accept.
- `shamt` input 5: shift amount, latched on accept.
- `busy` output 1: high in EXEC and SHIFT.
- `done` output 1: one-cycle pulse when `result` updates.
- `result` output 32: registered result, held until the next `done`.
- `zero` output 1: registered; `result == 0`, updated with `result`.
- `overflow` output 1: present only with `SEQ_ALU_OVF_EN`.

## Operation
- States: IDLE, EXEC, SHIFT. Reset enters IDLE.
- IDLE & `start`:
  - Latch operands and code.
  - Codes 0100/1000/1001 (SLL/SRL/SRA): shift register ← B, count ← shamt, go to SHIFT.
  - Any other code: go to EXEC.
- IDLE & !`start`: stay; outputs hold.
- EXEC: compute by code, load `result`/`zero`, pulse `done`, return to IDLE.
  - 0000 A&B
  - 0001 A|B
  - 0010 A+B
  - 0011 A^B
  - 0110 A−B
  - 0111 signed A<B ? 1 : 0
  - 1010 {B[15:0],16'h0}
  - 1100 ~(A|B)
  - Any other code: `result` = 0. `done` still pulses.
- SHIFT, count≠0: shift one bit and decrement count.
  - SLL: zero fill at bit 0.
  - SRL: zero fill at bit 31.
  - SRA: replicate bit 31.
- SHIFT, count==0: `result` ← shift register, pulse `done`, go to IDLE.
- Add and subtract are mod 2^32. SLT uses the 33-bit signed comparison.
- `start` while `busy` is ignored. Input changes after accept have no effect.

## Timing
- Reset values: `result`=0, `zero`=1, `done`=0, `busy`=0, `overflow`=0, state IDLE, count 0. Reset mid-operation aborts immediately with no `done`.
- Accept at edge E0. Let Dn denote the cycle following edge En (the cycle in which En's registered values are visible).
- Non-shift: `busy` high in D0; `result`/`done` valid in D1. Latency 1.
- Shift: `busy` high in D0 through D(shamt); `done` in D(shamt+1). Latency 1+shamt, so shamt=0 gives latency 1 and shamt=31 gives latency 32.
- `done` is high for exactly one cycle, with `busy`=0 in that cycle. `start` high during the `done` cycle is accepted at the next edge (back-to-back, no bubble).

## Configuration
- `SEQ_ALU_OVF_EN` defined:
  - `overflow` port exists and is registered with `result`.
  - ADD: 1 when A and B have the same sign and the result sign differs.
  - SUB: 1 when A and B differ in sign and the result sign differs from A.
  - All other codes: 0.
- `SEQ_ALU_OVF_EN` undefined: no `overflow` port and no overflow logic. All other behaviour is identical.

## Test plan
- Reset asserted mid-SHIFT (SLL, shamt=20, after 5 cycles) → `busy`=0 and `result`=0 asynchronously, `zero`=1, no `done` afterwards.
- ADD A=32'h7FFFFFFF, B=1 → `done` one cycle after accept, `result`=32'h80000000, `zero`=0; with `SEQ_ALU_OVF_EN`, `overflow`=1.
- SLT A=32'hFFFFFFFF, B=1 → `result`=1. SUB A=5, B=5 → `result`=0, `zero`=1.
- SRA B=32'h80000000, shamt=31 → `busy` high for 31 cycles after D0, `done` in D32, `result`=32'hFFFFFFFF. SRL with the same inputs → 32'h00000001.
- SLL B=1, shamt=0 → `done` at latency 1, `result`=1. LUI B=32'h00001234 → 32'h12340000. Code 4'b1111 → `result`=0 with a `done` pulse.
- Back-to-back: hold `start` high across AND(F0F0,FF00), then OR → consecutive results 0000F000 and 0000FFF0, each `done` one cycle. `start` pulsed while `busy` is ignored.
